// File: rtl/rv32i_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port
// unified instruction/data memory of the rv32i multicycle core.
module rv32i_mem_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic        RESET_LAST   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic        m0_wr_ena,
  output logic        m0_gnt,
  output logic [31:0] m0_rd_data,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic        m1_wr_ena,
  output logic        m1_gnt,
  output logic [31:0] m1_rd_data,
  output logic        m1_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        win;
  logic        last_grant;
  logic [1:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  logic        lat_we;
  logic        pick;
  logic        any_req;

  assign any_req = m0_req | m1_req;

  // On a tie the master that did not win last time goes first.
  assign pick = (m0_req & m1_req) ? ~last_grant : m1_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = lat_we ? S_DONE : S_WAIT;
      S_WAIT:   if (cnt == 2'd0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win        <= 1'b0;
      last_grant <= RESET_LAST;
      cnt        <= 2'd0;
      lat_addr   <= 32'd0;
      lat_wd     <= 32'd0;
      lat_we     <= 1'b0;
      m0_rd_data <= 32'd0;
      m1_rd_data <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            win      <= pick;
            lat_addr <= pick ? m1_addr    : m0_addr;
            lat_wd   <= pick ? m1_wr_data : m0_wr_data;
            lat_we   <= pick ? m1_wr_ena  : m0_wr_ena;
          end
        end
        S_ACCESS: begin
          if (!lat_we) cnt <= 2'(READ_LATENCY - 1);
        end
        S_WAIT: begin
          if (cnt == 2'd0) begin
            if (win) m1_rd_data <= mem_rd_data;
            else     m0_rd_data <= mem_rd_data;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_DONE: last_grant <= win;
        default: ;
      endcase
    end
  end

  logic busy;
  logic on_bus;

  // Outputs decode from state so reset clears them without a clock.
  assign busy   = (state != S_IDLE);
  assign on_bus = (state == S_ACCESS) | (state == S_WAIT);

  assign m0_gnt      = busy & ~win;
  assign m1_gnt      = busy & win;
  assign m0_done     = (state == S_DONE) & ~win;
  assign m1_done     = (state == S_DONE) & win;
  assign mem_addr    = on_bus ? lat_addr : 32'd0;
  assign mem_wr_data = on_bus ? lat_wd : 32'd0;
  assign mem_wr_ena  = (state == S_ACCESS) & lat_we;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: read, write,
// contention, latency sweep, reset mid-write, request churn.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_done;
  logic [31:0] m0_addr, m0_wd, m0_rd;
  logic        m1_req, m1_we, m1_gnt, m1_done;
  logic [31:0] m1_addr, m1_wd, m1_rd;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_data(m0_wd),
    .m0_wr_ena(m0_we), .m0_gnt(m0_gnt), .m0_rd_data(m0_rd),
    .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_data(m1_wd),
    .m1_wr_ena(m1_we), .m1_gnt(m1_gnt), .m1_rd_data(m1_rd),
    .m1_done(m1_done),
    .mem_addr(mem_addr), .mem_wr_data(mem_wd),
    .mem_wr_ena(mem_we), .mem_rd_data(mem_rd)
  );

  always_ff @(posedge clk) mem_rd <= mem_addr + 32'h1000;

  logic [3:0]        sw_req, sw_gnt, sw_done, sw_wen;
  logic [3:0]        sw_m1gnt, sw_m1done;
  logic [3:0][31:0]  sw_addr, sw_rd, sw_maddr, sw_mwd, sw_mrd, sw_m1rd;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    logic [3:0][31:0] p;
    rv32i_mem_arbiter #(.READ_LATENCY(g + 1)) u_sw (
      .clk(clk), .rst(rst),
      .m0_req(sw_req[g]), .m0_addr(sw_addr[g]),
      .m0_wr_data(32'd0), .m0_wr_ena(1'b0),
      .m0_gnt(sw_gnt[g]), .m0_rd_data(sw_rd[g]),
      .m0_done(sw_done[g]),
      .m1_req(1'b0), .m1_addr(32'd0), .m1_wr_data(32'd0),
      .m1_wr_ena(1'b0), .m1_gnt(sw_m1gnt[g]),
      .m1_rd_data(sw_m1rd[g]), .m1_done(sw_m1done[g]),
      .mem_addr(sw_maddr[g]), .mem_wr_data(sw_mwd[g]),
      .mem_wr_ena(sw_wen[g]), .mem_rd_data(sw_mrd[g])
    );
    always_ff @(posedge clk) begin
      p[0]   <= sw_maddr[g] + 32'h1000;
      p[3:1] <= p[2:0];
    end
    assign sw_mrd[g] = p[g];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  int          n;
  logic        bad;
  logic [31:0] exp_d, got_d;
  int          done_at [4];
  logic [31:0] got [4];

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
    sw_req = '0;
    for (int i = 0; i < 4; i++) sw_addr[i] = 32'h700 + 32'(i * 16);
    repeat (3) nc();
    chk("rst_ctl", {m0_gnt, m1_gnt, m0_done, m1_done, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wd", mem_wd, 0);
    chk("rst_rd0", m0_rd, 0);
    chk("rst_rd1", m1_rd, 0);
    rst = 1'b1;
    nc();

    // single read, master 0
    m0_req = 1; m0_addr = 32'h40;
    nc();
    chk("rd_gnt_c1", {m0_gnt, m1_gnt}, 2'b10);
    chk("rd_addr_c1", mem_addr, 32'h40);
    nc();
    chk("rd_addr_c2", mem_addr, 32'h40);
    chk("rd_done_c2", {m0_done, m1_done, mem_we}, 0);
    nc();
    chk("rd_done_c3", {m0_done, m1_done}, 2'b10);
    chk("rd_data", m0_rd, 32'h1040);
    chk("rd_m1_quiet", {m1_gnt, m1_done}, 0);
    chk("rd_m1_rd", m1_rd, 0);
    m0_req = 0;
    nc();
    chk("rd_idle", {m0_gnt, m0_done}, 0);

    // single write, master 1
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wd = 32'hDEADBEEF;
    nc();
    chk("wr_ctl_c1", {mem_we, m1_gnt, m0_gnt}, 3'b110);
    chk("wr_addr", mem_addr, 32'h80);
    chk("wr_data", mem_wd, 32'hDEADBEEF);
    nc();
    chk("wr_ctl_c2", {mem_we, m1_done}, 2'b01);
    chk("wr_rd_kept", m1_rd, 0);
    m1_req = 0; m1_we = 0;
    nc();
    chk("wr_ctl_c3", {mem_we, m1_done}, 0);

    // contention from reset: grants alternate 0,1,0,1
    rst = 1'b0;
    nc();
    rst = 1'b1;
    m0_req = 1; m0_addr = 32'h100;
    m1_req = 1; m1_addr = 32'h200;
    n = 0; bad = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      nc();
      if (m0_gnt & m1_gnt) bad = 1;
      if (m0_done & m1_done) bad = 1;
      if (m0_done | m1_done) begin
        chk("cont_order", {31'd0, m1_done}, 32'(n % 2));
        exp_d = (n % 2 == 1) ? 32'h1200 : 32'h1100;
        got_d = m1_done ? m1_rd : m0_rd;
        chk("cont_data", got_d, exp_d);
        n++;
      end
    end
    chk("cont_count", n, 4);
    chk("cont_excl", {31'd0, bad}, 0);
    m0_req = 0; m1_req = 0;
    nc();

    // reset in the middle of a write
    m0_req = 1; m0_we = 1; m0_addr = 32'h300; m0_wd = 32'h12345678;
    nc();
    chk("rw_we_before", mem_we, 1);
    #2 rst = 1'b0;
    #1;
    chk("rw_we_after", mem_we, 0);
    chk("rw_gnt_after", {m0_gnt, m1_gnt}, 0);
    m0_req = 0; m0_we = 0;
    nc();
    rst = 1'b1;
    bad = 0;
    repeat (3) begin
      nc();
      if (m0_done | m1_done) bad = 1;
    end
    chk("rw_no_done", {31'd0, bad}, 0);
    m0_req = 1; m0_addr = 32'h400;
    m1_req = 1; m1_addr = 32'h480;
    nc();
    chk("rw_tie_gnt", {m0_gnt, m1_gnt}, 2'b10);
    nc();
    nc();
    chk("rw_tie_done", {m0_done, m1_done}, 2'b10);
    chk("rw_tie_data", m0_rd, 32'h1400);
    m0_req = 0; m1_req = 0;
    nc();

    // request churn during the wait state
    m0_req = 1; m0_addr = 32'h500;
    nc();
    nc();
    m0_req = 0; m0_addr = 32'h600;
    #1;
    chk("churn_addr", mem_addr, 32'h500);
    chk("churn_gnt", m0_gnt, 1);
    nc();
    chk("churn_done", m0_done, 1);
    chk("churn_data", m0_rd, 32'h1500);
    nc();
    chk("churn_once", {m0_done, m0_gnt}, 0);
    chk("churn_bus", mem_addr, 0);

    // latency sweep, READ_LATENCY 1..4 side by side
    for (int i = 0; i < 4; i++) begin
      done_at[i] = 0;
      got[i] = 0;
    end
    sw_req = 4'hF;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      nc();
      if (sw_wen != 0) bad = 1;
      if ((sw_m1gnt | sw_m1done) != 0) bad = 1;
      for (int i = 0; i < 4; i++) begin
        if (sw_done[i]) begin
          if (done_at[i] == 0) begin
            done_at[i] = k;
            got[i] = sw_rd[i];
          end
          sw_req[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sweep_lat%0d", i + 1), done_at[i], i + 3);
      chk($sformatf("sweep_dat%0d", i + 1), got[i],
          32'h1700 + 32'(i * 16));
    end
    chk("sweep_quiet", {31'd0, bad}, 0);
    chk("sweep_idle", {28'd0, sw_gnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
